// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data-memory responder.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   // Size 11 falls through to a full word.
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
      case (size)
         SZ_BYTE: byte_en = 4'b0001 << a;
         SZ_HALF: byte_en = 4'b0011 << a;
         default: byte_en = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with byte write enables and registered read.
module dmem_ram #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W];

   // Read port only updates on a pure read so the last load value is held.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < 4; b++)
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         if (we == 4'b0000) rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port: wait states, stall, lane steering, error checks.
module dmem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_WORDS_LOG2 = 10,
   parameter int WAIT_CYCLES     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memreqM,
   input  logic        memwriteM,
   input  logic [31:0] aluoutM,
   input  logic [31:0] writedataM,
   input  logic [1:0]  sizeM,
   output logic [31:0] readdataM,
   output logic        stallM,
   output logic        ackM,
   output logic        errM
);

   state_t     state;
   logic [3:0] cnt;
   req_t       req;
   logic       rd_zero;

   logic                       fire, misaligned, out_of_range, bad;
   logic                       ram_en;
   logic [3:0]                 ram_we;
   logic [31:0]                ram_wdata, ram_q;
   logic [ADDR_WORDS_LOG2-1:0] word_idx;

   always_comb begin
      word_idx     = req.addr[ADDR_WORDS_LOG2+1:2];
      misaligned   = ((req.size == SZ_HALF) && req.addr[0]) ||
                     (req.size[1] && (req.addr[1:0] != 2'b00));
      out_of_range = (req.addr >> (ADDR_WORDS_LOG2 + 2)) != 32'd0;
      bad          = misaligned || out_of_range;
      fire         = (state == ST_BUSY) && (cnt == 4'd0);
      ram_en       = fire && !bad;
      ram_we       = req.we ? byte_en(req.size, req.addr[1:0]) : 4'b0000;
      case (req.size)
         SZ_BYTE: ram_wdata = {4{req.wdata[7:0]}};
         SZ_HALF: ram_wdata = {2{req.wdata[15:0]}};
         default: ram_wdata = req.wdata;
      endcase
   end

   dmem_ram #(.ADDR_W(ADDR_WORDS_LOG2)) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (word_idx),
      .wdata (ram_wdata),
      .rdata (ram_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         cnt     <= 4'd0;
         req     <= '0;
         ackM    <= 1'b0;
         errM    <= 1'b0;
         rd_zero <= 1'b1;
      end else begin
         ackM <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (memreqM) begin
                  req   <= '{we: memwriteM, size: sizeM, addr: aluoutM, wdata: writedataM};
                  cnt   <= 4'(WAIT_CYCLES);
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= ST_DONE;
                  ackM  <= 1'b1;
                  errM  <= bad;
                  // A good store leaves the previous read word visible.
                  if (bad)          rd_zero <= 1'b1;
                  else if (!req.we) rd_zero <= 1'b0;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign readdataM = rd_zero ? 32'd0 : ram_q;
   assign stallM    = memreqM && (state != ST_DONE);

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the pipelined MIPS core's data port. It accepts the core's memory-stage request (address, write strobe, write data, access size) and serves it from an internal byte-addressable word RAM. It applies a configurable number of wait states and holds the core's pipeline through the access with a stall line. Read data is returned as a raw word; the core performs sign/zero extension.

Parameters:
- ADDR_WORDS_LOG2, 10, RAM depth in 32-bit words (2^ADDR_WORDS_LOG2).
- WAIT_CYCLES, 2, extra BUSY cycles per access (0..15).

Ports:
- clk  in  1  core clock; all state is updated on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- memreqM  in  1  request valid: the memory-stage instruction is a load or a store.
- memwriteM  in  1  1 = store, 0 = load; meaningful only while memreqM is 1.
- aluoutM  in  32  byte address.
- writedataM  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- sizeM  in  2  access size: 00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
- readdataM  out  32  raw aligned word read from RAM; registered.
- stallM  out  1  combinational; the core holds the F/D/E/M stages while it is 1.
- ackM  out  1  one-cycle pulse that marks the access as complete.
- errM  out  1  misaligned or out-of-range access; valid in the cycle ackM is 1.

Behaviour:
- Reset (rst=0, asynchronous): state goes to IDLE and the counter to 0. readdataM, ackM and errM go to 0. RAM contents are not cleared. If reset arrives in mid-operation, the pending access is abandoned and an uncommitted store is dropped.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: when memreqM is 1, latch addr, wdata, size and we; load cnt with WAIT_CYCLES; go to BUSY.
  - BUSY: while cnt is not 0, decrement cnt. When cnt is 0, perform the RAM operation and go to DONE.
  - DONE: ackM is 1; readdataM and errM are updated. Next state is IDLE unconditionally.
- stallM = memreqM AND (state != DONE).
  - The core therefore sees WAIT_CYCLES+2 stall cycles per access and advances on the edge that ends DONE.
  - The next request is sampled in the following IDLE cycle, so there is no back-to-back overlap.
- Latency: the request is first visible in cycle 0. ackM and readdataM are valid in cycle WAIT_CYCLES+2.
- Requests are accepted only when state is IDLE. There is a single outstanding access.
- If memreqM drops during BUSY (pipeline flush), the latched access still completes and ackM still pulses. The core ignores that ack.
- Lane generation for stores, where a = addr[1:0]:
  - byte: be = 0001 << a; data = writedataM[7:0] replicated to all 4 lanes.
  - halfword: be = 0011 << a; data = writedataM[15:0] replicated to both halves.
  - word: be = 1111.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0] != 0.
  - errM is 1, no RAM write occurs, and readdataM is 0.
- Out-of-range access: addr[31:ADDR_WORDS_LOG2+2] != 0.
  - Same response as misaligned: errM is 1, no write, readdataM is 0.
- Reads return the full word at addr[ADDR_WORDS_LOG2+1:2], independent of size.
- readdataM holds its value until the next DONE.
- A store's DONE leaves readdataM unchanged. errM is cleared to 0 on a good access.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state encodings ST_IDLE, ST_BUSY, ST_DONE;
  - a function that builds byte-enables from size and address.
- One sub-module: dmem_ram.
  - Single-port synchronous RAM, 2^ADDR_WORDS_LOG2 x 32.
  - 4-bit byte-write enable, registered read, no reset.
- The responder holds the FSM, the wait counter, lane steering and error checks.

Test Plan:
- WAIT_CYCLES=2: store word 0xDEADBEEF to 0x10, then load 0x10 -> stallM is 1 for 4 cycles per access; ackM pulses in cycle 4; readdataM = 0xDEADBEEF; errM = 0.
- Byte store 0xAA to 0x21, then halfword store 0x1234 to 0x22, then word load 0x20 -> readdataM = 0x1234AA00 (lanes 0 and 1 were previously zeroed by a store of 0x00000000).
- WAIT_CYCLES=0 sweep: 8 consecutive loads -> each access has exactly 2 stall cycles, ackM is 1 cycle wide, and there is no overlap between requests.
- Misaligned and out-of-range cases:
  - word store to 0x13 -> errM = 1 and the RAM word at 0x10 is unchanged;
  - load at 0x00001000 with ADDR_WORDS_LOG2=10 -> errM = 1 and readdataM = 0.
- Reset mid-operation: assert rst low in the BUSY cycle of a store of 0x55 to 0x30 -> outputs go to 0 immediately; a later load of 0x30 returns the old value.
- Flush: drop memreqM during BUSY of a store of 0xCAFEF00D to 0x40 -> ackM still pulses; a later load of 0x40 returns 0xCAFEF00D.
